match_ctrl: RTL and testbench
=============================

# match_ctrl

Match sequencer for the pong game. It turns `start` and the `out_left`/`out_right` events from the game engine into a serve/play/point/game-over flow. It owns both 4-bit scores and freezes the ball between rallies. It issues a one-cycle `launch` (with a serve direction) to the game engine, and its scores drive the 7-segment scoreboard. It runs in the game-clock domain, with `tick` as the slow timing enable.

## Interface
- `WIN_SCORE`, default 9: score at which a player wins the match (1..15).
- `HOLD_TICKS`, default 1500: `tick` pulses of ball freeze before each serve (1 s at 1500 Hz).
- `HOLDW`, default 11: width of the hold counter; must satisfy `HOLD_TICKS < 2**HOLDW`.

Ports:
- `clk` in 1: the single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `tick` in 1: single-cycle timing enable.
- `start` in 1: debounced level; only its rising edge is acted on.
- `out_left` in 1: one-cycle pulse, ball left the field on the left (point to P2).
- `out_right` in 1: one-cycle pulse, ball left the field on the right (point to P1).
- `freeze` out 1: 1 = game engine holds the ball still.
- `launch` out 1: one-cycle pulse that starts a rally.
- `serve_dir` out 1: direction of the next serve, valid when `launch` is 1; 0 = toward left, 1 = toward right.
- `score_p1` out 4: player 1 score.
- `score_p2` out 4: player 2 score.
- `winner` out 2: 00 none, 01 P1, 10 P2.
- `state` out 2: IDLE=0, SERVE=1, PLAY=2, OVER=3.

## Operation
- All outputs are registered.
- Reset value of every output and internal register:
  - state IDLE, `freeze`=1, `launch`=0, `serve_dir`=0.
  - scores 0, `winner`=00, hold counter 0.
  - start edge-detect register 0.
- Reset mid-operation (any state, any counter value) returns to the reset values on the next edge.
- Start edge: `start_rise` = `start` & ~`start_q`; `start_q` samples `start` every cycle.
- IDLE:
  - `freeze`=1.
  - On `start_rise`: scores←0, `winner`←00, `serve_dir`←0, counter←HOLD_TICKS, go to SERVE.
- SERVE:
  - `freeze`=1.
  - If counter≠0 and `tick`: counter decrements by 1.
  - If counter==0: `launch`←1 and state←PLAY, both visible on the next cycle.
  - `tick` is irrelevant once the counter is 0.
- PLAY:
  - `freeze`=0.
  - `out_left` only: `score_p2`+1, `serve_dir`←0 (serve toward P1, who conceded).
  - `out_right` only: `score_p1`+1, `serve_dir`←1.
  - Both in the same cycle: no score change, `serve_dir` unchanged, re-serve.
  - After any of the three events:
    - If the new score equals WIN_SCORE, go to OVER and set `winner`.
    - Otherwise counter←HOLD_TICKS and go to SERVE.
- OVER:
  - `freeze`=1; scores and `winner` hold.
  - On `start_rise`: same actions as from IDLE.
- Ignored inputs:
  - `out_left`/`out_right` are ignored outside PLAY.
  - `start_rise` is ignored in SERVE and PLAY.
- Arithmetic:
  - Scores are 4-bit.
  - An increment never exceeds WIN_SCORE, so no wrap can occur.
  - The counter never underflows: decrement only when ≠0.

## Timing
- `out_*` pulse sampled at edge N: scores, `serve_dir`, state and `freeze` updated at N+1. `freeze` is 1 from N+1.
- Freeze duration:
  - Entering SERVE at edge E, with counter=H: `launch` is high for exactly one cycle, starting at the edge after the H-th counted `tick`.
  - HOLD_TICKS=0: `launch` at E+1.
- The `launch` cycle is the first PLAY cycle, with `freeze`=0. An `out_*` pulse in that same cycle is accepted.
- `start_rise` at edge N: state=SERVE and scores cleared at N+1.
- A `start` held high across the entry to OVER does not restart the match; a fresh rising edge is required.

## Test plan
Bench parameters: WIN_SCORE=3, HOLD_TICKS=2, `tick` every 4 cycles.

- Reset, then hold `start` low for 20 cycles -> state=0, `freeze`=1, `launch` never high, scores 0/0, `winner`=00.
- Pulse `start` -> state=1 on the next cycle. After 2 ticks, `launch`=1 for 1 cycle with `serve_dir`=0, then state=2 and `freeze`=0.
- In PLAY, pulse `out_right` -> next cycle `score_p1`=1, `serve_dir`=1, state=1, `freeze`=1. Re-launch after 2 ticks.
- In PLAY, pulse `out_left` and `out_right` together -> scores unchanged, state=1, `serve_dir` unchanged.
- P2 scores 3 times -> `score_p2`=3, `winner`=10, state=3. Further `out_*` pulses change nothing. A `start` held high is ignored. A new `start` rising edge -> scores 0/0, `winner`=00, state=1.
- Assert `reset` in SERVE with counter=1 -> all outputs at reset values on the next cycle. A `tick` arriving during `reset` has no effect.

Source files
------------

// File: rtl/match_ctrl.sv
// Pong match sequencer: serve/play/point/game-over flow, owns both scores and
// gates the ball with freeze/launch. All outputs are registered.
module match_ctrl #(
    parameter int unsigned WIN_SCORE  = 9,
    parameter int unsigned HOLD_TICKS = 1500,
    parameter int unsigned HOLDW      = 11
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       out_left,
    input  logic       out_right,
    output logic       freeze,
    output logic       launch,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] winner,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_e;

    localparam logic [3:0]       WIN  = 4'(WIN_SCORE);
    localparam logic [HOLDW-1:0] HOLD = HOLDW'(HOLD_TICKS);

    state_e           state_q;
    logic [HOLDW-1:0] cnt_q;
    logic             start_q;
    logic             freeze_q, launch_q, serve_dir_q;
    logic [3:0]       score_p1_q, score_p2_q;
    logic [1:0]       winner_q;

    logic             start_rise;
    logic [3:0]       score_p1_d, score_p2_d;

    assign start_rise = start & ~start_q;

    // Scores after a point; a simultaneous double-out is a replay with no score.
    always_comb begin
        score_p1_d = score_p1_q;
        score_p2_d = score_p2_q;
        if (out_right && !out_left) score_p1_d = score_p1_q + 4'd1;
        if (out_left && !out_right) score_p2_d = score_p2_q + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            start_q     <= 1'b0;
            freeze_q    <= 1'b1;
            launch_q    <= 1'b0;
            serve_dir_q <= 1'b0;
            score_p1_q  <= 4'd0;
            score_p2_q  <= 4'd0;
            winner_q    <= 2'b00;
        end else begin
            start_q  <= start;
            launch_q <= 1'b0;
            case (state_q)
                S_IDLE, S_OVER: begin
                    freeze_q <= 1'b1;
                    if (start_rise) begin
                        score_p1_q  <= 4'd0;
                        score_p2_q  <= 4'd0;
                        winner_q    <= 2'b00;
                        serve_dir_q <= 1'b0;
                        cnt_q       <= HOLD;
                        state_q     <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    // The launch cycle is already the first PLAY cycle, so unfreeze with it.
                    if (cnt_q == '0) begin
                        launch_q <= 1'b1;
                        freeze_q <= 1'b0;
                        state_q  <= S_PLAY;
                    end else if (tick) begin
                        cnt_q <= cnt_q - HOLDW'(1);
                    end
                end
                S_PLAY: begin
                    if (out_left || out_right) begin
                        score_p1_q <= score_p1_d;
                        score_p2_q <= score_p2_d;
                        freeze_q   <= 1'b1;
                        if (out_left ^ out_right) serve_dir_q <= out_right;
                        if (score_p1_d == WIN) begin
                            winner_q <= 2'b01;
                            state_q  <= S_OVER;
                        end else if (score_p2_d == WIN) begin
                            winner_q <= 2'b10;
                            state_q  <= S_OVER;
                        end else begin
                            cnt_q   <= HOLD;
                            state_q <= S_SERVE;
                        end
                    end
                end
            endcase
        end
    end

    assign freeze    = freeze_q;
    assign launch    = launch_q;
    assign serve_dir = serve_dir_q;
    assign score_p1  = score_p1_q;
    assign score_p2  = score_p2_q;
    assign winner    = winner_q;
    assign state     = state_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Bench for match_ctrl: directed match walk-through with literal checks, then
// randomized play compared every cycle against a behavioural match model.
module tb_match_ctrl;

    localparam int WIN  = 3;
    localparam int HOLD = 2;

    logic       clk = 1'b0, reset = 1'b1, tick = 1'b0, start = 1'b0;
    logic       out_left = 1'b0, out_right = 1'b0;
    logic       freeze, launch, serve_dir;
    logic [3:0] score_p1, score_p2;
    logic [1:0] winner, state;

    match_ctrl #(.WIN_SCORE(WIN), .HOLD_TICKS(HOLD), .HOLDW(4)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .out_left(out_left), .out_right(out_right),
        .freeze(freeze), .launch(launch), .serve_dir(serve_dir),
        .score_p1(score_p1), .score_p2(score_p2),
        .winner(winner), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Match model: phase 0 idle, 1 serving, 2 rally, 3 game over.
    int m_phase = 0, m_hold = 0, m_win = 0, m_dir = 0, m_launch = 0, m_prev = 0;
    int m_sc[2] = '{0, 0};
    bit live = 0;

    task automatic m_step();
        bit rise;
        if (reset) begin
            m_phase = 0; m_hold = 0; m_win = 0; m_dir = 0; m_launch = 0; m_prev = 0;
            m_sc[0] = 0; m_sc[1] = 0;
            return;
        end
        rise     = start && (m_prev == 0);
        m_prev   = start;
        m_launch = 0;
        if ((m_phase == 0 || m_phase == 3) && rise) begin
            m_sc[0] = 0; m_sc[1] = 0; m_win = 0; m_dir = 0;
            m_hold = HOLD; m_phase = 1;
        end else if (m_phase == 1) begin
            if (m_hold == 0) begin m_phase = 2; m_launch = 1; end
            else if (tick) m_hold--;
        end else if (m_phase == 2 && (out_left || out_right)) begin
            if (out_left != out_right) begin
                m_sc[out_right ? 0 : 1]++;
                m_dir = out_right;
            end
            if (m_sc[0] == WIN)      begin m_win = 1; m_phase = 3; end
            else if (m_sc[1] == WIN) begin m_win = 2; m_phase = 3; end
            else                     begin m_hold = HOLD; m_phase = 1; end
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("state",     state,     m_phase);
            chk("freeze",    freeze,    m_phase != 2);
            chk("launch",    launch,    m_launch);
            chk("serve_dir", serve_dir, m_dir);
            chk("score_p1",  score_p1,  m_sc[0]);
            chk("score_p2",  score_p2,  m_sc[1]);
            chk("winner",    winner,    m_win);
        end
    end

    int      tph = 0, nt = 0;
    bit      rnd_tick = 0;
    bit [1:0] th = 2'b00;

    // Apply one cycle of inputs; returns just after the edge that sampled them.
    task automatic cyc(input bit r, input bit st, input bit ol, input bit orr);
        reset = r; start = st; out_left = ol; out_right = orr;
        tick = rnd_tick ? ($urandom_range(2) == 0) : ((tph % 4) == 3);
        tph++;
        @(posedge clk);
        m_step();
        live = 1;
        #1;
        th = {th[0], tick};
        nt += int'(tick);
    endtask

    // Call right after the edge that entered SERVE.
    task automatic wait_launch(input string nm, input bit st);
        nt = 0;
        for (int i = 0; i < 60 && !launch; i++) cyc(0, st, 0, 0);
        chk({nm, " launch"}, launch, 1);
        chk({nm, " last tick before launch"}, th[1], 1);
        chk({nm, " ticks counted"}, nt - int'(th[0]), HOLD);
    endtask

    initial begin
        int seen;
        bit st;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst state", state, 0);   chk("rst freeze", freeze, 1);
        chk("rst launch", launch, 0); chk("rst dir", serve_dir, 0);
        chk("rst p1", score_p1, 0);   chk("rst p2", score_p2, 0);
        chk("rst winner", winner, 0);

        seen = 0;
        for (int i = 0; i < 20; i++) begin cyc(0, 0, 0, 0); seen |= int'(launch); end
        chk("idle no launch", seen, 0);
        chk("idle state", state, 0);

        cyc(0, 1, 0, 0);
        chk("start->serve", state, 1);
        wait_launch("serve1", 1);
        chk("serve1 dir", serve_dir, 0);
        chk("serve1 freeze", freeze, 0);
        chk("serve1 state", state, 2);
        cyc(0, 0, 0, 0);
        chk("launch one cycle", launch, 0);
        chk("play state", state, 2);

        cyc(0, 0, 0, 1);
        chk("p1 point", score_p1, 1); chk("p1 point dir", serve_dir, 1);
        chk("p1 point state", state, 1); chk("p1 point freeze", freeze, 1);
        wait_launch("serve2", 0);
        chk("serve2 dir", serve_dir, 1);

        cyc(0, 0, 1, 1);
        chk("double p1", score_p1, 1); chk("double p2", score_p2, 0);
        chk("double state", state, 1); chk("double dir", serve_dir, 1);
        wait_launch("serve3", 0);

        for (int k = 1; k <= WIN; k++) begin
            if (k == WIN) begin
                cyc(0, 1, 0, 0);
                cyc(0, 1, 1, 0);
            end else begin
                cyc(0, 0, 1, 0);
            end
            chk("p2 score", score_p2, k);
            chk("p2 dir", serve_dir, 0);
            if (k < WIN) wait_launch("serve p2", 0);
        end
        chk("over winner", winner, 2'b10);
        chk("over state", state, 3);
        chk("over freeze", freeze, 1);

        cyc(0, 1, 1, 0);
        cyc(0, 1, 0, 1);
        chk("over p1 hold", score_p1, 1); chk("over p2 hold", score_p2, 3);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0);
        chk("held start ignored", state, 3);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("restart state", state, 1);  chk("restart p1", score_p1, 0);
        chk("restart p2", score_p2, 0);  chk("restart winner", winner, 0);

        nt = 0;
        for (int i = 0; i < 20 && nt == 0; i++) cyc(0, 1, 0, 0);
        chk("one tick consumed", nt, 1);
        chk("still serving", state, 1);
        cyc(1, 1, 0, 0);
        chk("midreset state", state, 0); chk("midreset freeze", freeze, 1);
        chk("midreset launch", launch, 0);
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0);
        chk("reset w/ tick state", state, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);
        chk("after reset idle", state, 0);
        cyc(0, 1, 0, 0);
        wait_launch("post reset", 1);

        rnd_tick = 1;
        st = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(15) == 0) st = ~st;
            cyc($urandom_range(499) == 0, st, $urandom_range(5) == 0, $urandom_range(5) == 0);
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
